// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_signed(input op_e op_v);
    return (op_v == OP_MULT) || (op_v == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op_v);
    return (op_v == OP_DIV) || (op_v == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
module cond_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 sequential multiplier/divider sharing one adder and one set of shift registers.
//   state   | meaning
//   IDLE    | waiting for start
//   CALC    | one shift-add / shift-subtract step per cycle, N cycles
//   FIX     | sign correction, result written to hi/lo
//   DONE    | done pulse; start here begins the next operation
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned N = MULDIV_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;

  op_e          op_in;
  logic         sgn_in, sign_a, sign_b, b_zero;
  logic [N-1:0] abs_a, abs_b;

  assign op_in  = op_e'(op);
  assign sgn_in = op_is_signed(op_in);
  assign sign_a = sgn_in & A[N-1];
  assign sign_b = sgn_in & B[N-1];
  assign b_zero = (B == '0);

  cond_negate #(.W(N)) u_abs_a (.a_i(A), .neg_i(sign_a), .y_o(abs_a));
  cond_negate #(.W(N)) u_abs_b (.a_i(B), .neg_i(sign_b), .y_o(abs_b));

  // Single adder: multiply adds the multiplicand, divide subtracts the divisor (carry-out = no borrow).
  logic [N:0]   shifted, add_a, add_b, mult_t;
  logic [N+1:0] add_res;
  logic         no_borrow;

  assign shifted   = {acc_q, sreg_q[N-1]};
  assign add_a     = is_div_q ? shifted : {1'b0, acc_q};
  assign add_b     = is_div_q ? ~{1'b0, mcand_q} : {1'b0, mcand_q};
  assign add_res   = {1'b0, add_a} + {1'b0, add_b} + {{(N+1){1'b0}}, is_div_q};
  assign no_borrow = add_res[N+1];
  assign mult_t    = sreg_q[0] ? add_res[N:0] : {1'b0, acc_q};

  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  cond_negate #(.W(2*N)) u_fix_prod (.a_i({acc_q, sreg_q}), .neg_i(neg_res_q), .y_o(prod_fix));
  cond_negate #(.W(N))   u_fix_quo  (.a_i(sreg_q),          .neg_i(neg_res_q), .y_o(quo_fix));
  cond_negate #(.W(N))   u_fix_rem  (.a_i(acc_q),           .neg_i(neg_rem_q), .y_o(rem_fix));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    sreg_d    = sreg_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_CALC;
          cnt_d    = CW'(N);
          is_div_d = op_is_div(op_in);
          acc_d    = '0;
          if (op_is_div(op_in)) begin
            sreg_d    = abs_a;
            mcand_d   = abs_b;
            // Divide by zero keeps the all-ones quotient unsigned.
            neg_res_d = (sign_a ^ sign_b) & ~b_zero;
            neg_rem_d = sign_a;
          end else begin
            sreg_d    = abs_b;
            mcand_d   = abs_a;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = 1'b0;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          acc_d  = no_borrow ? add_res[N-1:0] : shifted[N-1:0];
          sreg_d = {sreg_q[N-2:0], no_borrow};
        end else begin
          acc_d  = mult_t[N:1];
          sreg_d = {mult_t[0], sreg_q[N-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      sreg_q    <= '0;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      sreg_q    <= sreg_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: N, default 32, operand/result width; N SHALL be even and >= 4.
REQ-002 Port: clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 Port: start  in  1  request; sampled only in IDLE or DONE.
REQ-005 Port: op  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 Port: A, B  in  N each  operands; captured on the accepting edge, ignored afterwards.
REQ-007 Port: busy  out  1  high while an operation is in progress.
REQ-008 Port: done  out  1  one-cycle completion pulse.
REQ-009 Port: hi, lo  out  N each  result registers.
- Multiply: {hi,lo} = 2N-bit product.
- Divide: lo = quotient, hi = remainder.

Function
REQ-010 FSM states SHALL be IDLE, CALC, FIX and DONE.
REQ-011 Transitions SHALL be:
- IDLE --start--> CALC
- CALC --after N iterations--> FIX
- FIX --> DONE
- DONE --start--> CALC
- DONE --no start--> IDLE
REQ-012 On acceptance the unit SHALL capture op, the operand magnitudes (absolute values for signed ops) and the result-sign flags, and SHALL load the iteration counter with N.
REQ-013 CALC SHALL perform one radix-2 step per cycle:
- Multiply: shift-add.
- Divide: restoring shift-subtract on an (N+1)-bit partial remainder.
REQ-014 FIX SHALL apply two's-complement sign correction:
- Product negated if sign(A) xor sign(B) for mult.
- Quotient negated if sign(A) xor sign(B) for div.
- Remainder takes the sign of A for div.
REQ-015 hi/lo SHALL update only on the edge entering DONE and SHALL hold until the next such edge.
REQ-016 Latency: done SHALL be high exactly N+2 cycles after the start-accepting edge, for one cycle.
REQ-017 Throughput: start asserted while in DONE SHALL be accepted, giving back-to-back operations every N+2 cycles.
REQ-018 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-019 start asserted in CALC or FIX SHALL be ignored and SHALL NOT be queued.
REQ-020 Divide by zero (B == 0), both div and divu, SHALL complete with normal latency and yield lo = all ones, hi = A.
REQ-021 Signed overflow (div, A = -2^(N-1), B = -1) SHALL yield lo = -2^(N-1), hi = 0.
REQ-022 Signed mult with operand -2^(N-1) SHALL produce the exact 2N-bit product.
REQ-023 All datapath arithmetic SHALL be unsigned on magnitudes; no signed-typed arithmetic.

Reset
REQ-024 While reset == 0 at a rising edge, the unit SHALL enter IDLE with busy = 0, done = 0, hi = 0, lo = 0, and counter and datapath registers cleared.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; hi/lo SHALL read 0 after the reset edge.
REQ-026 Reset SHALL take priority over start.

Structure
REQ-027 Package muldiv_pkg SHALL hold:
- op encoding enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
- FSM state enum.
- Default width constant.
REQ-028 One sub-module, cond_negate, SHALL be used for conditional two's-complement negation of operands and results.
REQ-029 The divider and multiplier SHALL share the shift registers and the single adder/subtractor.

Verification (N = 32)
REQ-030 mult A = -3 (0xFFFFFFFD), B = 7 -> done after 34 cycles; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-031 multu A = B = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-032 div A = -7, B = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; divu A = 7, B = 0 -> lo = 0xFFFFFFFF, hi = 7.
REQ-033 div A = 0x80000000, B = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
REQ-034 Back-to-back and ignore test:
- start held high for 3 consecutive operations -> done pulses spaced 34 cycles apart.
- start pulses during CALC -> no extra done, hi/lo unchanged.
REQ-035 Mid-operation reset: reset = 0 for one cycle during CALC cycle 10 -> no done pulse; busy = 0, hi = lo = 0 next cycle; a new op then completes normally.
